// File: rtl/cpu_regfile_sb_pkg.sv
// Shared constants and types for the CPU register file with scoreboard.
package cpu_pkg;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_idx_t;

  typedef enum logic {RF_CLEAR, RF_READY} regfile_state_t;
endpackage

// File: rtl/cpu_regfile_sb_if.sv
// Decode/writeback bus between the pipeline (master) and the register file (slave).
interface cpu_regfile_sb_if
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned NUM_RD   = 2
) ();
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]   p2_rd_reg;
  logic [NUM_RD*XLEN-1:0] p2_rd_data;
  logic [NUM_RD-1:0]      p2_rd_pending;
  logic                   p2_claim_en;
  logic [AW-1:0]          p2_claim_reg;
  logic [AW-1:0]          p4_reg_d;
  logic                   p4_write_en;
  logic [XLEN-1:0]        p4_reg_data_d;
  logic                   busy;

  modport master (
    output p2_rd_reg, p2_claim_en, p2_claim_reg, p4_reg_d, p4_write_en, p4_reg_data_d,
    input  p2_rd_data, p2_rd_pending, busy
  );

  modport slave (
    input  p2_rd_reg, p2_claim_en, p2_claim_reg, p4_reg_d, p4_write_en, p4_reg_data_d,
    output p2_rd_data, p2_rd_pending, busy
  );
endinterface

// File: rtl/cpu_regfile_sb_scoreboard.sv
// Per-register pending bits: set on claim, cleared on writeback, with lookup per read port.
module cpu_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 i_ready,
  input  logic                 i_claim_en,
  input  logic [AW-1:0]        i_claim_reg,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_reg,
  input  logic [NUM_RD*AW-1:0] i_rd_reg,
  output logic [NUM_RD-1:0]    o_pending
);
  logic [NUM_REGS-1:0] r_sb;
  logic                w_claim_ok;
  logic                w_wr_ok;

  assign w_claim_ok = i_claim_en && !((ZERO_REG != 0) && (i_claim_reg == '0));
  assign w_wr_ok    = i_wr_en    && !((ZERO_REG != 0) && (i_wr_reg == '0));

  // Claim is applied after the clear so a same-register claim/retire leaves the bit set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sb <= '0;
    end else if (i_ready) begin
      if (w_wr_ok)    r_sb[i_wr_reg]    <= 1'b0;
      if (w_claim_ok) r_sb[i_claim_reg] <= 1'b1;
    end
  end

  always_comb begin
    o_pending = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      o_pending[i] = i_ready && r_sb[i_rd_reg[i*AW +: AW]] &&
                     !(i_wr_en && (i_wr_reg == i_rd_reg[i*AW +: AW]));
    end
  end
endmodule

// File: rtl/cpu_regfile_sb.sv
// Register file with write-to-read bypass, pending scoreboard and post-reset clear sequencer.
module cpu_regfile_sb
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              resetn,
  cpu_regfile_sb_if.slave   bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  regfile_state_t         r_state;
  logic [AW-1:0]          r_clear_idx;
  logic                   r_busy;
  logic [XLEN-1:0]        r_regs [NUM_REGS];
  logic                   w_ready;
  logic                   w_wr_ok;
  logic [NUM_RD*XLEN-1:0] w_rd_data;

  assign w_ready = (r_state == RF_READY);
  assign w_wr_ok = w_ready && bus.p4_write_en &&
                   !((ZERO_REG != 0) && (bus.p4_reg_d == '0));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= RF_CLEAR;
      r_clear_idx <= '0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_clear_idx <= r_clear_idx + 1'b1;
          if (r_clear_idx == AW'(NUM_REGS - 1)) begin
            r_state <= RF_READY;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= RF_READY;
      endcase
    end
  end

  // Storage has no reset of its own; the clear sequencer owns initialisation.
  always_ff @(posedge clock) begin
    if (r_state == RF_CLEAR) begin
      r_regs[r_clear_idx] <= '0;
    end else if (w_wr_ok) begin
      r_regs[bus.p4_reg_d] <= bus.p4_reg_data_d;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (!w_ready || ((ZERO_REG != 0) && (bus.p2_rd_reg[i*AW +: AW] == '0))) begin
        w_rd_data[i*XLEN +: XLEN] = '0;
      end else if (w_wr_ok && (bus.p4_reg_d == bus.p2_rd_reg[i*AW +: AW])) begin
        w_rd_data[i*XLEN +: XLEN] = bus.p4_reg_data_d;
      end else begin
        w_rd_data[i*XLEN +: XLEN] = r_regs[bus.p2_rd_reg[i*AW +: AW]];
      end
    end
  end

  assign bus.p2_rd_data = w_rd_data;
  assign bus.busy       = r_busy;

  cpu_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock       (clock),
    .resetn      (resetn),
    .i_ready     (w_ready),
    .i_claim_en  (bus.p2_claim_en),
    .i_claim_reg (bus.p2_claim_reg),
    .i_wr_en     (bus.p4_write_en),
    .i_wr_reg    (bus.p4_reg_d),
    .i_rd_reg    (bus.p2_rd_reg),
    .o_pending   (bus.p2_rd_pending)
  );
endmodule
